// File: rtl/dense_layer_tm.sv
// dense_layer_tm -- time-multiplexed fully-connected layer.
//
// P_LANES MAC lanes evaluate NN neurons in ceil(NN/P_LANES) passes over one
// buffered input vector. Weights and biases arrive over a shared config bus.
// Results stream out one neuron per out_valid/out_ready handshake.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   weightValid/weightValue   weight write strobe / value ([DATA_W-1:0] used)
//   biasValid/biasValue       bias write strobe / value ([DATA_W-1:0] used)
//   config_layer_num          target layer of a config write
//   config_neuron_num         target neuron of a config write
//   x_valid/x_ready/x_in      input sample stream, index order 0..NUM_IN-1
//   out_valid/out_ready       result handshake
//   out_data/out_idx          activated neuron output and its neuron index
//   busy                      high while computing or draining results
module dense_layer_tm #(
  parameter int    NN        = 10,
  parameter int    NUM_IN    = 784,
  parameter int    P_LANES   = 2,
  parameter int    DATA_W    = 16,
  parameter int    INT_W     = 4,
  parameter int    LAYER_NUM = 1,
  parameter string ACT_TYPE  = "relu",
  localparam int   IDX_W     = (NN > 1) ? $clog2(NN) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              weightValid,
  input  logic              biasValid,
  input  logic [31:0]       weightValue,
  input  logic [31:0]       biasValue,
  input  logic [31:0]       config_layer_num,
  input  logic [31:0]       config_neuron_num,
  input  logic              x_valid,
  output logic              x_ready,
  input  logic [DATA_W-1:0] x_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              busy
);

  localparam int FRAC   = DATA_W - INT_W;
  localparam int NPASS  = (NN + P_LANES - 1) / P_LANES;
  localparam int DEPTH  = NPASS * NUM_IN;
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PTR_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int CNT_W  = $clog2(NUM_IN + 3);
  localparam int PASS_W = (NPASS > 1) ? $clog2(NPASS) : 1;
  localparam int LANE_W = (P_LANES > 1) ? $clog2(P_LANES) : 1;
  localparam int ACC_W  = 2 * DATA_W + $clog2(NUM_IN);
  localparam bit IS_RELU = (ACT_TYPE == "relu");

  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(NUM_IN - 1);
  localparam logic [CNT_W-1:0]  CNT_IN    = CNT_W'(NUM_IN);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(NUM_IN + 2);
  localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(NPASS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_DRAIN} state_t;

  // ---------------- configuration path ----------------
  logic        cfg_hit;
  logic [31:0] last_nrn_q;
  logic [PTR_W-1:0] wptr_q, wptr_eff, wptr_d;
  logic [31:0] cfg_lane32, cfg_addr32;
  logic signed [DATA_W-1:0] bias_q [NN];

  assign cfg_hit    = (config_layer_num == 32'(LAYER_NUM)) &&
                      (config_neuron_num < 32'(NN));
  assign cfg_lane32 = config_neuron_num % 32'(P_LANES);
  assign cfg_addr32 = (config_neuron_num / 32'(P_LANES)) * 32'(NUM_IN) + 32'(wptr_eff);

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    // A new target neuron restarts its weight sequence at index 0.
    wptr_eff = (config_neuron_num != last_nrn_q) ? '0 : wptr_q;
    wptr_d   = wptr_eff;
    if (weightValid && cfg_hit)
      wptr_d = (wptr_eff == PTR_LAST) ? '0 : wptr_eff + 1'b1;
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q     <= '0;
      last_nrn_q <= '0;
      for (int i = 0; i < NN; i++) bias_q[i] <= '0;
    end else begin
      wptr_q     <= wptr_d;
      last_nrn_q <= config_neuron_num;
      if (biasValid && cfg_hit)
        bias_q[config_neuron_num[IDX_W-1:0]] <= biasValue[DATA_W-1:0];
    end
  end

  // ---------------- control state ----------------
  state_t              state_q;
  logic [PTR_W-1:0]    in_ptr_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [PASS_W-1:0]   pass_q;
  logic [LANE_W-1:0]   dl_q;
  logic                v1_q, v2_q;
  logic                x_ready_q, out_valid_q, busy_q;
  logic [DATA_W-1:0]   out_data_q;
  logic [IDX_W-1:0]    out_idx_q;

  // Read index for this cycle; held at 0 during the pipeline flush cycles.
  logic [PTR_W-1:0]  rd_k;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_addr32;
  assign rd_k      = (cnt_q < CNT_IN) ? cnt_q[PTR_W-1:0] : '0;
  assign rd_addr32 = 32'(pass_q) * 32'(NUM_IN) + 32'(rd_k);
  assign rd_addr   = rd_addr32[ADDR_W-1:0];

  // ---------------- input buffer ----------------
  logic signed [DATA_W-1:0] xbuf [NUM_IN];
  logic signed [DATA_W-1:0] x_rd_q;

  // NOTE: buffer and RAM arrays carry no reset; their contents are only ever
  // consumed after being written, and resetting them would block RAM mapping.
  always_ff @(posedge clk) begin
    if (state_q == S_LOAD && x_valid) xbuf[in_ptr_q] <= x_in;
    x_rd_q <= xbuf[rd_k];
  end

  // ---------------- MAC lanes ----------------
  logic signed [ACC_W-1:0] acc_q [P_LANES];

  for (genvar l = 0; l < P_LANES; l++) begin : g_lane
    logic signed [DATA_W-1:0]   mem [DEPTH];
    logic signed [DATA_W-1:0]   w_rd_q;
    logic signed [2*DATA_W-1:0] prod_q;
    logic [31:0]                nrn;
    logic signed [DATA_W-1:0]   b_sel;

    assign nrn   = 32'(pass_q) * 32'(P_LANES) + 32'(l);
    assign b_sel = (nrn < 32'(NN)) ? bias_q[nrn[IDX_W-1:0]] : '0;

    always_ff @(posedge clk) begin
      if (weightValid && cfg_hit && cfg_lane32 == 32'(l))
        mem[cfg_addr32[ADDR_W-1:0]] <= weightValue[DATA_W-1:0];
      w_rd_q <= mem[rd_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        prod_q   <= '0;
        acc_q[l] <= '0;
      end else begin
        prod_q <= x_rd_q * w_rd_q;
        if (state_q == S_COMPUTE) begin
          // Accumulator starts each pass at the bias aligned to the product scale.
          if (cnt_q == '0)  acc_q[l] <= ACC_W'(b_sel) <<< FRAC;
          else if (v2_q)    acc_q[l] <= acc_q[l] + ACC_W'(prod_q);
        end
      end
    end
  end

  // Scale back, saturate, then apply the activation.
  function automatic logic [DATA_W-1:0] activate(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    logic [DATA_W-1:0]       r;
    s = a >>> FRAC;
    if (s > SAT_MAX)      r = SAT_MAX[DATA_W-1:0];
    else if (s < SAT_MIN) r = SAT_MIN[DATA_W-1:0];
    else                  r = s[DATA_W-1:0];
    if (IS_RELU && r[DATA_W-1]) r = '0;
    return r;
  endfunction

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_LOAD;
      in_ptr_q    <= '0;
      cnt_q       <= '0;
      pass_q      <= '0;
      dl_q        <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      x_ready_q   <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
    end else begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      case (state_q)
        S_LOAD: begin
          if (x_valid) begin
            if (in_ptr_q == PTR_LAST) begin
              in_ptr_q  <= '0;
              pass_q    <= '0;
              cnt_q     <= '0;
              x_ready_q <= 1'b0;
              busy_q    <= 1'b1;
              state_q   <= S_COMPUTE;
            end else begin
              in_ptr_q <= in_ptr_q + 1'b1;
            end
          end
        end
        S_COMPUTE: begin
          v1_q <= (cnt_q < CNT_IN);
          v2_q <= v1_q;
          if (cnt_q == CNT_LAST) begin
            dl_q        <= '0;
            out_valid_q <= 1'b1;
            out_data_q  <= activate(acc_q[0]);
            out_idx_q   <= IDX_W'(32'(pass_q) * 32'(P_LANES));
            state_q     <= S_DRAIN;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            // Lanes past NN in the last pass are skipped, never emitted.
            if (32'(dl_q) < 32'(P_LANES - 1) && 32'(out_idx_q) + 1 < 32'(NN)) begin
              dl_q       <= dl_q + 1'b1;
              out_data_q <= activate(acc_q[dl_q + 1'b1]);
              out_idx_q  <= out_idx_q + 1'b1;
            end else begin
              out_valid_q <= 1'b0;
              if (pass_q == PASS_LAST) begin
                x_ready_q <= 1'b1;
                busy_q    <= 1'b0;
                state_q   <= S_LOAD;
              end else begin
                pass_q  <= pass_q + 1'b1;
                cnt_q   <= '0;
                state_q <= S_COMPUTE;
              end
            end
          end
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

  assign x_ready   = x_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_dense_layer_tm.sv
// Testbench for dense_layer_tm: a relu and a linear instance share all
// stimulus; expected results are queued by the stimulus and checked by an
// independent monitor at each output handshake.
module tb_dense_layer_tm;
  localparam int NN = 3, NUM_IN = 4, P = 2, DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, weightValid, biasValid, x_valid, out_ready;
  logic [31:0] weightValue, biasValue, config_layer_num, config_neuron_num;
  logic [15:0] x_in;
  logic        r_x_ready, r_out_valid, r_busy, l_x_ready, l_out_valid, l_busy;
  logic [15:0] r_out_data, l_out_data;
  logic [1:0]  r_out_idx, l_out_idx;

  dense_layer_tm #(.NN(NN), .NUM_IN(NUM_IN), .P_LANES(P), .DATA_W(DW), .INT_W(4),
                   .LAYER_NUM(1), .ACT_TYPE("relu")) u_relu (
    .clk(clk), .rst(rst), .weightValid(weightValid), .biasValid(biasValid),
    .weightValue(weightValue), .biasValue(biasValue),
    .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
    .x_valid(x_valid), .x_ready(r_x_ready), .x_in(x_in),
    .out_valid(r_out_valid), .out_ready(out_ready), .out_data(r_out_data),
    .out_idx(r_out_idx), .busy(r_busy));

  dense_layer_tm #(.NN(NN), .NUM_IN(NUM_IN), .P_LANES(P), .DATA_W(DW), .INT_W(4),
                   .LAYER_NUM(1), .ACT_TYPE("linear")) u_lin (
    .clk(clk), .rst(rst), .weightValid(weightValid), .biasValid(biasValid),
    .weightValue(weightValue), .biasValue(biasValue),
    .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
    .x_valid(x_valid), .x_ready(l_x_ready), .x_in(x_in),
    .out_valid(l_out_valid), .out_ready(out_ready), .out_data(l_out_data),
    .out_idx(l_out_idx), .busy(l_busy));

  typedef struct {
    logic [1:0]  idx;
    logic [15:0] relu;
    logic [15:0] lin;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [1:0] idx, input logic [15:0] r, input logic [15:0] l);
    exp_t e;
    e.idx = idx; e.relu = r; e.lin = l;
    sb.push_back(e);
  endtask

  // Writes four weights (index 0 in the low 16 bits) and the bias of one neuron.
  task automatic cfg(input int layer, input int n, input logic [63:0] wv, input logic [15:0] b);
    config_layer_num  = 32'(layer);
    config_neuron_num = 32'(n);
    for (int i = 0; i < NUM_IN; i++) begin
      weightValid = 1'b1;
      weightValue = {16'h0, wv[i*16 +: 16]};
      step();
    end
    weightValid = 1'b0;
    biasValid   = 1'b1;
    biasValue   = {16'h0, b};
    step();
    biasValid   = 1'b0;
  endtask

  task automatic send_vec(input logic [63:0] xv);
    for (int i = 0; i < NUM_IN; i++) begin
      x_valid = 1'b1;
      x_in    = xv[i*16 +: 16];
      step();
    end
    x_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      if (sb.size() == 0 && r_x_ready && !r_out_valid) done = 1'b1;
      else step();
    end
    check(name, 32'(done), 32'd1);
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    bit          held = 1'b0;
    logic [15:0] hold_data;
    logic [1:0]  hold_idx;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check("hold_data", 32'(r_out_data), 32'(hold_data));
          check("hold_idx", 32'(r_out_idx), 32'(hold_idx));
        end
        if (r_out_valid && out_ready) begin
          held = 1'b0;
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_out: got idx %0d data %h, expected no output",
                     r_out_idx, r_out_data);
          end else begin
            e = sb.pop_front();
            check("out_idx", 32'(r_out_idx), 32'(e.idx));
            check("relu_data", 32'(r_out_data), 32'(e.relu));
            check("lin_valid", 32'(l_out_valid), 32'd1);
            check("lin_idx", 32'(l_out_idx), 32'(e.idx));
            check("lin_data", 32'(l_out_data), 32'(e.lin));
          end
        end else if (r_out_valid) begin
          held      = 1'b1;
          hold_data = r_out_data;
          hold_idx  = r_out_idx;
        end else begin
          held = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [63:0] ONES = {4{16'h1000}};

  initial begin : stim
    bit seen;
    rst = 1'b1; weightValid = 1'b0; biasValid = 1'b0; x_valid = 1'b0; out_ready = 1'b1;
    weightValue = '0; biasValue = '0; config_layer_num = '0; config_neuron_num = '0;
    x_in = '0;
    repeat (3) step();
    check("rst_x_ready", 32'(r_x_ready), 32'd1);
    check("rst_out_valid", 32'(r_out_valid), 32'd0);
    check("rst_out_data", 32'(r_out_data), 32'd0);
    check("rst_out_idx", 32'(r_out_idx), 32'd0);
    check("rst_busy", 32'(r_busy), 32'd0);
    check("rst_lin_x_ready", 32'(l_x_ready), 32'd1);
    rst = 1'b0;
    step();

    // T1: unit weights, zero bias, unit inputs -> 4.0 for every neuron.
    for (int n = 0; n < NN; n++) cfg(1, n, ONES, 16'h0000);
    for (int n = 0; n < NN; n++) push(2'(n), 16'h4000, 16'h4000);
    send_vec(ONES);
    check("t1_x_ready_low", 32'(r_x_ready), 32'd0);
    check("t1_busy", 32'(r_busy), 32'd1);
    wait_done("t1_done");

    // T2: positive and negative saturation.
    for (int n = 0; n < NN; n++) cfg(1, n, {4{16'h2000}}, 16'h0000);
    for (int n = 0; n < NN; n++) push(2'(n), 16'h7FFF, 16'h7FFF);
    send_vec({4{16'h2000}});
    wait_done("t2a_done");
    for (int n = 0; n < NN; n++) cfg(1, n, {4{16'hE000}}, 16'h0000);
    for (int n = 0; n < NN; n++) push(2'(n), 16'h0000, 16'h8000);
    send_vec({4{16'h2000}});
    wait_done("t2b_done");

    // T3: neuron 1 goes negative (-4.0 + 0.5 = -3.5).
    cfg(1, 0, ONES, 16'h0000);
    cfg(1, 1, {4{16'hF000}}, 16'h0800);
    cfg(1, 2, ONES, 16'h0000);
    push(2'd0, 16'h4000, 16'h4000);
    push(2'd1, 16'h0000, 16'hC800);
    push(2'd2, 16'h4000, 16'h4000);
    send_vec(ONES);
    wait_done("t3_done");

    // T4: back-pressure on the first result.
    cfg(1, 1, ONES, 16'h0000);
    for (int n = 0; n < NN; n++) push(2'(n), 16'h4000, 16'h4000);
    out_ready = 1'b0;
    send_vec(ONES);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (r_out_valid) seen = 1'b1;
      else step();
    end
    check("t4_valid_seen", 32'(seen), 32'd1);
    repeat (5) step();
    out_ready = 1'b1;
    wait_done("t4_done");

    // T5: neuron 2 lives in the second, partial pass.
    cfg(1, 2, {4{16'h0000}}, 16'h1000);
    push(2'd0, 16'h4000, 16'h4000);
    push(2'd1, 16'h4000, 16'h4000);
    push(2'd2, 16'h1000, 16'h1000);
    send_vec(ONES);
    wait_done("t5_done");

    // T6: reset in the middle of COMPUTE; weights survive, biases clear.
    cfg(1, 2, ONES, 16'h0000);
    send_vec(ONES);
    repeat (3) step();
    check("t6_busy_pre", 32'(r_busy), 32'd1);
    rst = 1'b1;
    #1;
    check("t6_out_valid", 32'(r_out_valid), 32'd0);
    check("t6_x_ready", 32'(r_x_ready), 32'd1);
    check("t6_busy", 32'(r_busy), 32'd0);
    step();
    rst = 1'b0;
    step();
    for (int n = 0; n < NN; n++) push(2'(n), 16'h4000, 16'h4000);
    send_vec(ONES);
    wait_done("t6_done");

    // T7: per-index weight/input alignment and ignored config writes.
    cfg(1, 0, {16'h1000, 16'h0C00, 16'h0800, 16'h0400}, 16'h0000);
    cfg(1, 1, ONES, 16'h0000);
    cfg(1, 2, {4{16'hF000}}, 16'h0000);
    cfg(2, 0, {4{16'h7000}}, 16'h7000);   // wrong layer
    cfg(1, 3, {4{16'h7000}}, 16'h7000);   // neuron out of range
    push(2'd0, 16'h2400, 16'h2400);
    push(2'd1, 16'h4000, 16'h4000);
    push(2'd2, 16'h0000, 16'hC000);
    send_vec({16'h1000, 16'h0000, 16'h2000, 16'h1000});
    wait_done("t7_done");

    repeat (20) step();
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
